// File: rtl/inst_fetch_aligner_if.sv
// Fetch/decode bundle between memory, the instruction aligner and decode.
// Latency: n/a (signal bundle only).
// Backpressure: mem_ready throttles memory; out_ready throttles the aligner.
interface inst_fetch_aligner_if;
    logic [31:0] fetch_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        flush;
    logic [31:0] flush_pc;

    // aligner side
    modport master (
        output fetch_addr, mem_ready, out_valid, out_inst, out_pc,
        input  mem_valid, mem_data, out_ready, flush, flush_pc
    );

    // memory/decode/redirect side
    modport slave (
        input  fetch_addr, mem_ready, out_valid, out_inst, out_pc,
        output mem_valid, mem_data, out_ready, flush, flush_pc
    );
endinterface

// File: rtl/inst_fetch_aligner.sv
// Splits word-aligned 32-bit fetch data into 16/32-bit instructions with PCs.
// Latency: first instruction valid the cycle after the first accepted word.
// Backpressure: mem_ready drops when 3+ halfwords are queued; out_valid ignores out_ready.
module inst_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    inst_fetch_aligner_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0033;

    // halfword queue, head at hb_q[0]
    logic [3:0][15:0] hb_q, hb_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fa_q, fa_d;
    logic             skip_q, skip_d;

    logic       compressed;
    logic       has_insn;
    logic       accept;
    logic       consume;
    logic [1:0] pop_n;
    logic [2:0] base;
    logic [1:0] idx;

    assign compressed = (hb_q[0][1:0] != 2'b11);
    // a 32-bit head with only its low half queued is the straddle wait
    assign has_insn   = compressed ? (cnt_q >= 3'd1) : (cnt_q >= 3'd2);

    assign bus.out_valid  = !bus.flush && has_insn;
    assign bus.out_inst   = !bus.out_valid ? NOP :
                            compressed     ? {16'h0000, hb_q[0]} : {hb_q[1], hb_q[0]};
    assign bus.out_pc     = pc_q;
    assign bus.fetch_addr = fa_q;
    assign bus.mem_ready  = (cnt_q <= 3'd2) && !bus.flush;

    assign accept  = bus.mem_valid && bus.mem_ready;
    assign consume = bus.out_valid && bus.out_ready;
    assign pop_n   = !consume ? 2'd0 : (compressed ? 2'd1 : 2'd2);

    // next state: pop the consumed instruction, push accepted halves behind it; flush wins
    always_comb begin
        hb_d   = hb_q;
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        fa_d   = fa_q;
        skip_d = skip_q;
        base   = cnt_q - {1'b0, pop_n};
        idx    = base[1:0];

        case (pop_n)
            2'd1:    hb_d = {hb_q[3], hb_q[3:1]};
            2'd2:    hb_d = {hb_q[3:2], hb_q[3:2]};
            default: hb_d = hb_q;
        endcase
        pc_d  = pc_q + {29'd0, pop_n, 1'b0};
        cnt_d = base;

        if (accept) begin
            fa_d = fa_q + 32'd4;
            if (skip_q) begin
                // redirect landed on the upper half: drop the lower one
                hb_d[idx] = bus.mem_data[31:16];
                cnt_d     = base + 3'd1;
                skip_d    = 1'b0;
            end else begin
                hb_d[idx]        = bus.mem_data[15:0];
                hb_d[idx + 2'd1] = bus.mem_data[31:16];
                cnt_d            = base + 3'd2;
            end
        end

        if (bus.flush) begin
            hb_d   = hb_q;
            cnt_d  = 3'd0;
            pc_d   = bus.flush_pc & ~32'd1;
            fa_d   = bus.flush_pc & ~32'd3;
            skip_d = bus.flush_pc[1];
        end
    end

    // state registers with asynchronous reset to the boot PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_q   <= '0;
            cnt_q  <= 3'd0;
            pc_q   <= RESET_PC & ~32'd1;
            fa_q   <= RESET_PC & ~32'd3;
            skip_q <= RESET_PC[1];
        end else begin
            hb_q   <= hb_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            fa_q   <= fa_d;
            skip_q <= skip_d;
        end
    end
endmodule

// File: doc/inst_fetch_aligner.md
Name: inst_fetch_aligner

Overview:
- Front-end stage that sits between the instruction memory and the RVC decompression stage.
- Takes word-aligned 32-bit fetch data and splits it into a stream of 16-bit compressed or 32-bit full instructions, each with its PC.
- Handles 32-bit instructions that straddle word boundaries, redirects to half-word-aligned targets, and back-pressure from decode.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first instruction after reset (bit 0 ignored).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
fetch_addr  output  32  word-aligned address presented to instruction memory
mem_valid  input  1  mem_data is valid for the current fetch_addr
mem_data  input  32  fetched word, little-endian halfwords
mem_ready  output  1  aligner accepts mem_data this cycle
out_valid  output  1  out_inst/out_pc hold a complete instruction
out_ready  input  1  decode consumes the instruction this cycle
out_inst  output  32  instruction; compressed form is zero-extended {16'h0000, hw}
out_pc  output  32  PC of out_inst
flush  input  1  redirect request (taken branch/jump)
flush_pc  input  32  redirect target (bit 0 ignored)

Behaviour:
- Storage: 4-entry halfword queue hb[0..3] with count cnt (0..4), head at hb[0]. The queue is a shifting register or a circular buffer with a head pointer; either is acceptable.
- Additional registers: pc_q (32), fa_q (fetch address, 32), skip (1).
- Reset (rst=0, async): cnt=0, pc_q=RESET_PC&~1, fa_q=RESET_PC&~3, skip=RESET_PC[1]. Resulting outputs: out_valid=0, out_inst=32'h0000_0033 (NOP), out_pc=pc_q, mem_ready=1.
- fetch_addr = fa_q.
- mem_ready = (cnt<=2) && !flush. Accept happens when mem_valid && mem_ready.
- Accept with skip=0: push mem_data[15:0], then mem_data[31:16] (cnt+=2).
- Accept with skip=1: push only mem_data[31:16] (cnt+=1), then clear skip.
- Every accept: fa_q += 4.
- A compressed instruction is one with hb[0][1:0] != 2'b11.
- out_valid = !flush && ((cnt>=1 && compressed) || (cnt>=2 && !compressed)). It is combinational from registered state and flush only, with no dependency on out_ready.
- out_inst: compressed gives {16'h0000, hb[0]}; 32-bit gives {hb[1], hb[0]}; otherwise NOP.
- out_pc = pc_q.
- Consume when out_valid && out_ready: pop 1 (compressed) or 2 halfwords, and pc_q += 2 or 4 respectively.
- Consume and accept in the same cycle: both apply. Pop first, then push. The next cnt = cnt - popped + pushed, which never exceeds 4.
- Straddle: a 32-bit instruction whose low half is the last queued halfword stays invalid (out_valid=0) until the next word is accepted. There are no bubbles beyond this wait.
- Flush has priority over everything in its cycle:
  - cnt=0; pc_q=flush_pc&~1; fa_q=flush_pc&~3; skip=flush_pc[1].
  - mem_data presented that cycle is dropped (mem_ready=0).
  - No consume occurs (out_valid=0).
- Latency:
  - After reset or flush, the first instruction is valid the cycle after the first accepted word.
  - Sustained throughput is one instruction per cycle while memory keeps up.
- Memory stall (mem_valid=0): the queue drains. out_valid drops when cnt=0, or when cnt=1 with a 32-bit head.
- Decode stall (out_ready=0): the queue fills. mem_ready deasserts at cnt>=3 and fa_q holds.
- Wrap-around: pc_q and fa_q wrap modulo 2^32 with no special handling.
- Reset asserted mid-operation overrides everything asynchronously, including an in-progress straddle or flush.

Test Plan:
- Reset with RESET_PC=0, mem_data=32'h4501_4505 (two C instructions): out_pc=0 then 2; out_inst=32'h0000_4505 then 32'h0000_4501; fetch_addr advances 0→4→8.
- Straddle: word0=32'h0093_4505, word1=32'h1234_0010. Required: C insn at pc 0; 32-bit insn 32'h0010_0093 at pc 2, valid only after word1 is accepted; C insn 32'h0000_1234 at pc 6.
- Back-pressure: hold out_ready=0 with mem_valid=1. mem_ready falls once cnt reaches 3 or 4 and fetch_addr freezes. On releasing out_ready, no instruction is lost or duplicated (compare against the golden stream).
- Flush to flush_pc=32'h0000_0102 while mem_valid=1. That cycle: out_valid=0, mem_ready=0. Next: fetch_addr=32'h100, the low half of word 0x100 is discarded, and the first out_pc=32'h102.
- Flush in the same cycle as out_valid && out_ready: pc_q equals flush_pc&~1 (not pc+2/4), and the queue is empty.
- Async reset asserted mid-straddle (cnt=1, 32-bit head): immediately out_valid=0 and fetch_addr=RESET_PC&~3, independent of clk.
